// File: rtl/freq_setpoint_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// freq_ctrl_pkg
// Shared constants and encodings for the frequency setpoint controller:
// range limits/steps, range (mode) encoding, button FSM states and step
// direction. No ports.
// -----------------------------------------------------------------------------
package freq_ctrl_pkg;

  localparam int FREQ_W = 12;

  localparam logic [FREQ_W-1:0] LO_MIN  = 12'd1;
  localparam logic [FREQ_W-1:0] LO_MAX  = 12'd100;
  localparam logic [FREQ_W-1:0] LO_STEP = 12'd1;
  localparam logic [FREQ_W-1:0] HI_MIN  = 12'd1000;
  localparam logic [FREQ_W-1:0] HI_MAX  = 12'd2000;
  localparam logic [FREQ_W-1:0] HI_STEP = 12'd100;

  typedef enum logic {
    MODE_LO = 1'b0,   // 1..100 Hz
    MODE_HI = 1'b1    // 1000..2000 Hz
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

endpackage

// File: rtl/freq_setpoint_ctrl_if.sv
// -----------------------------------------------------------------------------
// freq_setpoint_ctrl_if
// Valid/ready setpoint channel from the controller to the generator.
//   set_valid : set_freq holds a setpoint not yet accepted
//   set_ready : generator accepts the setpoint this cycle
//   set_freq  : setpoint in Hz
// master = controller side, slave = generator side.
// -----------------------------------------------------------------------------
interface freq_setpoint_ctrl_if;
  import freq_ctrl_pkg::*;

  logic              set_valid;
  logic              set_ready;
  logic [FREQ_W-1:0] set_freq;

  modport master (output set_valid, output set_freq, input set_ready);
  modport slave  (input  set_valid, input  set_freq, output set_ready);
endinterface

// File: rtl/freq_setpoint_ctrl_btn_repeat.sv
// -----------------------------------------------------------------------------
// btn_repeat
// Converts debounced up/down button levels into one-cycle step pulses:
// one step on press, first auto-repeat step REPEAT_DLY cycles later, then
// one every REPEAT_PER cycles while held. A second button pressed during a
// hold aborts the hold without stepping.
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_btn_up, i_btn_dn     : debounced button levels
//   o_step_up, o_step_dn   : registered single-cycle step pulses
// -----------------------------------------------------------------------------
module btn_repeat
  import freq_ctrl_pkg::*;
#(
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_up,
  input  logic i_btn_dn,
  output logic o_step_up,
  output logic o_step_dn
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

  logic             r_up_d;
  logic             r_dn_d;
  btn_state_e       r_state;
  dir_e             r_dir;
  logic [CNT_W-1:0] r_cnt;

  logic w_rise_up;
  logic w_rise_dn;
  logic w_act_lvl;
  logic w_oth_lvl;

  assign w_rise_up = i_btn_up & ~r_up_d;
  assign w_rise_dn = i_btn_dn & ~r_dn_d;
  // Level of the button that started the hold, and of the other one.
  assign w_act_lvl = (r_dir == DIR_UP) ? i_btn_up : i_btn_dn;
  assign w_oth_lvl = (r_dir == DIR_UP) ? i_btn_dn : i_btn_up;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_up_d    <= 1'b0;
      r_dn_d    <= 1'b0;
      r_state   <= ST_IDLE;
      r_dir     <= DIR_NONE;
      r_cnt     <= '0;
      o_step_up <= 1'b0;
      o_step_dn <= 1'b0;
    end else begin
      r_up_d    <= i_btn_up;
      r_dn_d    <= i_btn_dn;
      o_step_up <= 1'b0;
      o_step_dn <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A press counts only if the other button is low, which also
          // rejects simultaneous presses and presses while the other is held.
          if (w_rise_up && !i_btn_dn) begin
            r_state   <= ST_HOLD;
            r_dir     <= DIR_UP;
            r_cnt     <= '0;
            o_step_up <= 1'b1;
          end else if (w_rise_dn && !i_btn_up) begin
            r_state   <= ST_HOLD;
            r_dir     <= DIR_DN;
            r_cnt     <= '0;
            o_step_dn <= 1'b1;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (!w_act_lvl || w_oth_lvl) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_NONE;
          end else if (r_cnt == ((r_state == ST_HOLD) ? DLY_LAST : PER_LAST)) begin
            r_state   <= ST_REPEAT;
            r_cnt     <= '0;
            o_step_up <= (r_dir == DIR_UP);
            o_step_dn <= (r_dir == DIR_DN);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_dir   <= DIR_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/freq_setpoint_ctrl.sv
// -----------------------------------------------------------------------------
// freq_setpoint_ctrl
// Turns button steps into frequency setpoints over two ranges with
// cross-range wrap, and offers each setpoint to the generator over a
// valid/ready channel with a one-deep deferred step.
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_btn_up, i_btn_dn     : debounced button levels
//   set_if (master)        : set_valid/set_freq out, set_ready in
//   o_cur_freq             : latest committed setpoint (display)
//   o_mode                 : range, 0 = 1..100 Hz, 1 = 1000..2000 Hz
//   o_busy                 : transfer outstanding or step deferred
// -----------------------------------------------------------------------------
module freq_setpoint_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_btn_up,
  input  logic               i_btn_dn,
  freq_setpoint_ctrl_if.master set_if,
  output logic [FREQ_W-1:0]  o_cur_freq,
  output logic               o_mode,
  output logic               o_busy
);

  // Returns {mode, freq} after one step in direction d.
  function automatic logic [FREQ_W:0] step_freq(input logic [FREQ_W-1:0] f,
                                                input logic m, input dir_e d);
    logic              m_n;
    logic [FREQ_W-1:0] f_n;
    m_n = m;
    f_n = f;
    if (d == DIR_UP) begin
      if (m == MODE_LO) begin
        if (f >= LO_MAX) begin m_n = MODE_HI; f_n = HI_MIN; end
        else             f_n = f + LO_STEP;
      end else begin
        if (f >= HI_MAX) begin m_n = MODE_LO; f_n = LO_MIN; end
        else             f_n = f + HI_STEP;
      end
    end else if (d == DIR_DN) begin
      if (m == MODE_LO) begin
        if (f <= LO_MIN) begin m_n = MODE_HI; f_n = HI_MAX; end
        else             f_n = f - LO_STEP;
      end else begin
        if (f <= HI_MIN) begin m_n = MODE_LO; f_n = LO_MAX; end
        else             f_n = f - HI_STEP;
      end
    end
    return {m_n, f_n};
  endfunction

  logic w_step_up;
  logic w_step_dn;

  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_btn_repeat (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_btn_up  (i_btn_up),
    .i_btn_dn  (i_btn_dn),
    .o_step_up (w_step_up),
    .o_step_dn (w_step_dn)
  );

  logic              r_init_done;
  logic              r_valid;
  logic [FREQ_W-1:0] r_set_freq;
  logic [FREQ_W-1:0] r_cur_freq;
  logic              r_mode;
  dir_e              r_defer;
  logic              r_busy;

  dir_e              w_step_dir;
  dir_e              w_eff_dir;
  logic              w_xfer;
  logic [FREQ_W:0]   w_stepped;
  logic              w_apply;
  logic              w_nxt_valid;
  dir_e              w_nxt_defer;

  always_comb begin
    w_step_dir  = w_step_up ? DIR_UP : (w_step_dn ? DIR_DN : DIR_NONE);
    w_xfer      = r_valid & set_if.set_ready;
    // A step arriving this cycle is newer than any deferred one.
    w_eff_dir   = (w_step_dir != DIR_NONE) ? w_step_dir : r_defer;
    w_stepped   = step_freq(r_cur_freq, r_mode, w_eff_dir);
    w_apply     = 1'b0;
    w_nxt_valid = r_valid;
    w_nxt_defer = r_defer;
    if (!r_init_done) begin
      // First cycle out of reset: offer the reset setpoint to align the generator.
      w_nxt_valid = 1'b1;
    end else if (r_valid) begin
      if (w_xfer) begin
        w_nxt_defer = DIR_NONE;
        if (w_eff_dir != DIR_NONE) w_apply = 1'b1;
        else                       w_nxt_valid = 1'b0;
      end else begin
        w_nxt_defer = w_eff_dir;
      end
    end else if (w_step_dir != DIR_NONE) begin
      w_apply     = 1'b1;
      w_nxt_valid = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_init_done <= 1'b0;
      r_valid     <= 1'b0;
      r_set_freq  <= LO_MIN;
      r_cur_freq  <= LO_MIN;
      r_mode      <= MODE_LO;
      r_defer     <= DIR_NONE;
      r_busy      <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
      r_valid     <= w_nxt_valid;
      r_defer     <= w_nxt_defer;
      r_busy      <= w_nxt_valid | (w_nxt_defer != DIR_NONE);
      if (w_apply) begin
        r_mode     <= w_stepped[FREQ_W];
        r_cur_freq <= w_stepped[FREQ_W-1:0];
        r_set_freq <= w_stepped[FREQ_W-1:0];
      end
    end
  end

  assign set_if.set_valid = r_valid;
  assign set_if.set_freq  = r_set_freq;
  assign o_cur_freq       = r_cur_freq;
  assign o_mode           = r_mode;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_freq_setpoint_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_setpoint_ctrl
// Directed scenarios plus randomized button/ready traffic, compared every
// cycle against a reference model that treats the setpoint as a position in
// the ordered list of legal frequencies and auto-repeat as hold age.
// -----------------------------------------------------------------------------
module tb_freq_setpoint_ctrl;

  localparam int DLY = 20;
  localparam int PER = 4;
  localparam int NF  = 111;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_dn = 1'b0;
  logic [11:0] cur_freq;
  logic        mode;
  logic        busy;

  freq_setpoint_ctrl_if u_if ();

  freq_setpoint_ctrl #(
    .REPEAT_DLY (DLY),
    .REPEAT_PER (PER)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn_up   (btn_up),
    .i_btn_dn   (btn_dn),
    .set_if     (u_if),
    .o_cur_freq (cur_freq),
    .o_mode     (mode),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model state.
  int freqs [NF];
  int m_idx, m_setf, m_defer, m_step, m_active, m_age;
  bit m_valid, m_init, m_up_p, m_dn_p;

  task automatic model_reset();
    m_idx = 0; m_setf = 1; m_valid = 0; m_defer = 0; m_init = 0;
    m_step = 0; m_active = 0; m_age = 0; m_up_p = 0; m_dn_p = 0;
  endtask

  task automatic model_apply(input int d);
    m_idx  = (m_idx + d + NF) % NF;
    m_setf = freqs[m_idx];
  endtask

  // One clock edge with the given sampled inputs. Directions are +1/-1/0.
  task automatic model_edge(input bit up, input bit dn, input bit rdy);
    int eff;
    bit rise_u, rise_d;
    if (!m_init) begin
      m_init = 1; m_valid = 1; m_setf = 1;
    end else begin
      eff = (m_step != 0) ? m_step : m_defer;
      if (m_valid && rdy) begin
        m_defer = 0;
        if (eff != 0) model_apply(eff);
        else          m_valid = 0;
      end else if (m_valid) begin
        m_defer = eff;
      end else if (m_step != 0) begin
        model_apply(m_step);
        m_valid = 1;
      end
    end
    rise_u = up && !m_up_p;
    rise_d = dn && !m_dn_p;
    m_step = 0;
    if (m_active == 0) begin
      if (rise_u && !dn)      begin m_active = 1;  m_age = 0; m_step = 1;  end
      else if (rise_d && !up) begin m_active = -1; m_age = 0; m_step = -1; end
    end else begin
      if ((m_active == 1) ? (!up || dn) : (!dn || up)) begin
        m_active = 0;
      end else begin
        m_age++;
        if (m_age == DLY || (m_age > DLY && (m_age - DLY) % PER == 0)) m_step = m_active;
      end
    end
    m_up_p = up;
    m_dn_p = dn;
  endtask

  task automatic compare_all();
    check("set_valid", int'(u_if.set_valid), int'(m_valid));
    check("set_freq",  int'(u_if.set_freq),  m_setf);
    check("cur_freq",  int'(cur_freq),       freqs[m_idx]);
    check("mode",      int'(mode),           (m_idx >= 100) ? 1 : 0);
    check("busy",      int'(busy),           (m_valid || m_defer != 0) ? 1 : 0);
  endtask

  // Called at a falling edge: drive inputs, advance model, step one cycle.
  task automatic tick(input bit up, input bit dn, input bit rdy);
    btn_up = up;
    btn_dn = dn;
    u_if.set_ready = rdy;
    if (rst_n) model_edge(up, dn, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input bit up, input bit rdy);
    repeat (2) tick(up, !up, rdy);
    repeat (2) tick(1'b0, 1'b0, rdy);
  endtask

  // Asserts reset between clock edges, checks outputs right away, then
  // releases on a falling edge so the next rising edge is the INIT edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", int'(u_if.set_valid), 0);
    check("rst_setf",  int'(u_if.set_freq),  1);
    check("rst_cur",   int'(cur_freq),       1);
    check("rst_mode",  int'(mode),           0);
    check("rst_busy",  int'(busy),           0);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    u_if.set_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit u, d;
    for (int i = 0; i < 100; i++) freqs[i] = i + 1;
    for (int i = 0; i < 11; i++)  freqs[100 + i] = 1000 + 100 * i;
    model_reset();
    u_if.set_ready = 1'b0;
    @(negedge clk);

    // Reset and INIT alignment.
    do_reset();
    tick(0, 0, 1);
    check("init_valid", int'(u_if.set_valid), 1);
    check("init_setf",  int'(u_if.set_freq),  1);
    check("init_mode",  int'(mode),           0);
    tick(0, 0, 1);
    check("init_drop",  int'(u_if.set_valid), 0);

    // Range wraps.
    press(0, 1);
    check("wrap_1_dn", int'(cur_freq), 2000);
    check("wrap_1_dn_mode", int'(mode), 1);
    press(1, 1);
    check("wrap_2000_up", int'(cur_freq), 1);
    check("wrap_2000_up_mode", int'(mode), 0);
    repeat (11) press(0, 1);
    check("down_to_1000", int'(cur_freq), 1000);
    press(0, 1);
    check("wrap_1000_dn", int'(cur_freq), 100);
    check("wrap_1000_dn_mode", int'(mode), 0);
    press(1, 1);
    check("wrap_100_up", int'(cur_freq), 1000);
    check("wrap_100_up_mode", int'(mode), 1);
    repeat (11) press(1, 1);
    repeat (4) press(1, 1);
    check("at_5", int'(cur_freq), 5);

    // Auto-repeat: 30 cycles held -> four steps.
    repeat (30) tick(1, 0, 1);
    repeat (3) tick(0, 0, 1);
    check("autorep", int'(cur_freq), 9);

    // Deferral with generator stalled.
    press(1, 1);
    press(1, 0);
    press(1, 0);
    check("defer_setf",  int'(u_if.set_freq),  11);
    check("defer_busy",  int'(busy),           1);
    check("defer_valid", int'(u_if.set_valid), 1);
    tick(0, 0, 1);
    check("defer_next",  int'(u_if.set_freq),  12);
    check("defer_hold",  int'(u_if.set_valid), 1);
    tick(0, 0, 1);
    check("defer_done",  int'(u_if.set_valid), 0);
    check("defer_idle",  int'(busy),           0);
    check("defer_cur",   int'(cur_freq),       12);

    // Simultaneous presses.
    repeat (3) tick(1, 1, 1);
    repeat (2) tick(0, 0, 1);
    check("simul_nostep", int'(cur_freq), 12);
    repeat (3) tick(1, 0, 1);
    repeat (40) tick(1, 1, 1);
    repeat (2) tick(0, 0, 1);
    check("abort_hold", int'(cur_freq), 13);

    // Randomized traffic.
    u = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) u = ~u;
      if ($urandom_range(0, 11) == 0) d = ~d;
      tick(u, d, ($urandom_range(0, 3) != 0));
    end
    repeat (4) tick(0, 0, 1);

    // Reset while a setpoint of 1500 is outstanding.
    do_reset();
    repeat (2) tick(0, 0, 1);
    press(0, 1);
    repeat (4) press(0, 1);
    press(0, 0);
    check("pre_rst_setf",  int'(u_if.set_freq),  1500);
    check("pre_rst_valid", int'(u_if.set_valid), 1);
    do_reset();
    tick(0, 0, 1);
    check("reinit_valid", int'(u_if.set_valid), 1);
    check("reinit_setf",  int'(u_if.set_freq),  1);
    tick(0, 0, 1);
    check("reinit_drop",  int'(u_if.set_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
